// File: rtl/edram_sched.sv
// edram_sched: slot scheduler and refresh controller for the 32-row x 325-bit
// eDRAM macro. One read requester, one write requester and an internal refresh
// engine share the macro's single port, one operation per 4-clk slot.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   rd_req_i/rd_addr_i            read request (held until rd_gnt_o)
//   rd_gnt_o                      read grant, pulse in issue cycle T
//   rd_valid_o/rd_data_o          read return at T+4
//   wr_req_i/wr_addr_i/wr_data_i  write request (held until wr_gnt_o)
//   wr_gnt_o                      write grant, pulse at T
//   ref_overflow_o                sticky: refresh tick lost at saturation
//   port_*                        macro-side strobes, addresses and data
module edram_sched #(
  parameter int unsigned REF_INTERVAL = 256,
  parameter int unsigned REF_PEND_MAX = 4,
  parameter int unsigned REF_URGENT   = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rd_req_i,
  input  logic [4:0]   rd_addr_i,
  output logic         rd_gnt_o,
  output logic         rd_valid_o,
  output logic [324:0] rd_data_o,
  input  logic         wr_req_i,
  input  logic [4:0]   wr_addr_i,
  input  logic [324:0] wr_data_i,
  output logic         wr_gnt_o,
  output logic         ref_overflow_o,
  output logic         port_en_o,
  output logic         port_ref_plus2_o,
  output logic [4:0]   port_read_addr_o,
  input  logic [324:0] port_read_data_i,
  output logic [4:0]   port_write_addr_o,
  output logic [324:0] port_write_data_o,
  output logic         port_wen_plus3_o,
  output logic         port_data_plus3_o
);

  localparam int unsigned TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  // Operation owning the current slot; held for all four phases so the
  // issue strobes (phase 0) and the writeback strobes (phase 3) share it.
  typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE, OP_REF} op_e;

  op_e           op_q, op_d;
  logic [1:0]    phase_q, phase_d;
  logic [4:0]    row_q, row_d;
  logic [324:0]  wdata_q, wdata_d;
  logic          rdv_q, rdv_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    pend_q, pend_d;
  logic [4:0]    ref_row_q, ref_row_d;
  logic          ovf_q, ovf_d;

  logic arb, tick, dec, issue, wb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= OP_IDLE;
      phase_q   <= '0;
      row_q     <= '0;
      wdata_q   <= '0;
      rdv_q     <= 1'b0;
      timer_q   <= '0;
      pend_q    <= '0;
      ref_row_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      phase_q   <= phase_d;
      row_q     <= row_d;
      wdata_q   <= wdata_d;
      rdv_q     <= rdv_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      ref_row_q <= ref_row_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    op_d      = op_q;
    phase_d   = phase_q + 2'd1;
    row_d     = row_q;
    wdata_d   = wdata_q;
    rdv_d     = 1'b0;
    ref_row_d = ref_row_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    dec       = 1'b0;

    // Arbitration on the edge ending phase 3; winner owns the next slot.
    arb  = (phase_q == 2'd3);
    tick = (timer_q == TW'(REF_INTERVAL - 1));
    timer_d = tick ? '0 : timer_q + 1'b1;

    if (arb) begin
      // Read data returns in phase 0 of the slot after the read.
      rdv_d = (op_q == OP_READ);
      if (pend_q >= 8'(REF_URGENT)) begin
        op_d = OP_REF;
      end else if (wr_req_i) begin
        op_d = OP_WRITE;
      end else if (rd_req_i) begin
        op_d = OP_READ;
      end else if (pend_q != 8'd0) begin
        op_d = OP_REF;
      end else begin
        op_d = OP_IDLE;
      end

      unique case (op_d)
        OP_REF: begin
          row_d     = ref_row_q;
          ref_row_d = ref_row_q + 5'd1;
          dec       = 1'b1;
        end
        OP_WRITE: begin
          row_d   = wr_addr_i;
          wdata_d = wr_data_i;
        end
        OP_READ: row_d = rd_addr_i;
        default: row_d = row_q;
      endcase
    end

    // A tick and a refresh issue on the same edge cancel out.
    if (tick && !dec) begin
      if (pend_q == 8'(REF_PEND_MAX)) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 8'd1;
      end
    end else if (dec && !tick) begin
      pend_d = pend_q - 8'd1;
    end

    issue = (phase_q == 2'd0);
    wb    = (phase_q == 2'd3);

    rd_gnt_o          = issue && (op_q == OP_READ);
    wr_gnt_o          = issue && (op_q == OP_WRITE);
    port_en_o         = issue && ((op_q == OP_READ) || (op_q == OP_WRITE));
    port_ref_plus2_o  = issue && (op_q == OP_REF);
    port_read_addr_o  = (issue && (op_q != OP_IDLE)) ? row_q : '0;
    port_wen_plus3_o  = wb && (op_q != OP_IDLE);
    port_data_plus3_o = wb && (op_q == OP_WRITE);
    port_write_addr_o = port_wen_plus3_o ? row_q : '0;
    port_write_data_o = port_data_plus3_o ? wdata_q : '0;
    rd_valid_o        = rdv_q;
    rd_data_o         = rdv_q ? port_read_data_i : '0;
    ref_overflow_o    = ovf_q;
  end

endmodule

// File: tb/tb_edram_sched.sv
// Testbench for edram_sched. Four instances with different refresh settings:
//   0: 256/4/3 (defaults), 1: 16/4/3, 2: 8/4/3, 3: 16/2/3.
module tb_edram_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         rst [4];
  logic         rd_req [4];
  logic [4:0]   rd_addr [4];
  logic         rd_gnt [4];
  logic         rd_valid [4];
  logic [324:0] rd_data [4];
  logic         wr_req [4];
  logic [4:0]   wr_addr [4];
  logic [324:0] wr_data [4];
  logic         wr_gnt [4];
  logic         ovf [4];
  logic         en [4];
  logic         refp [4];
  logic [4:0]   raddr [4];
  logic [324:0] prd [4];
  logic [4:0]   waddr [4];
  logic [324:0] wdo [4];
  logic         wen [4];
  logic         dp3 [4];

  // Expected per-cycle values for the randomized run.
  logic [6:0]   e_st [1024];
  logic [4:0]   e_ra [1024];
  logic [4:0]   e_wa [1024];
  logic [324:0] e_wd [1024];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned IV = (g == 0) ? 256 : (g == 2) ? 8 : 16;
    localparam int unsigned PM = (g == 3) ? 2 : 4;
    edram_sched #(.REF_INTERVAL(IV), .REF_PEND_MAX(PM), .REF_URGENT(3)) u_dut (
      .clk_i(clk), .rst_i(rst[g]),
      .rd_req_i(rd_req[g]), .rd_addr_i(rd_addr[g]), .rd_gnt_o(rd_gnt[g]),
      .rd_valid_o(rd_valid[g]), .rd_data_o(rd_data[g]),
      .wr_req_i(wr_req[g]), .wr_addr_i(wr_addr[g]), .wr_data_i(wr_data[g]),
      .wr_gnt_o(wr_gnt[g]), .ref_overflow_o(ovf[g]),
      .port_en_o(en[g]), .port_ref_plus2_o(refp[g]),
      .port_read_addr_o(raddr[g]), .port_read_data_i(prd[g]),
      .port_write_addr_o(waddr[g]), .port_write_data_o(wdo[g]),
      .port_wen_plus3_o(wen[g]), .port_data_plus3_o(dp3[g])
    );
  end

  // {rd_gnt, wr_gnt, port_en, port_ref, wen, data_plus3, rd_valid}
  function automatic logic [6:0] strobes(input int d);
    return {rd_gnt[d], wr_gnt[d], en[d], refp[d], wen[d], dp3[d], rd_valid[d]};
  endfunction

  function automatic logic [324:0] rnd325();
    logic [351:0] t;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom();
    return t[324:0];
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller in cycle 0 (first cycle with rst low).
  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    rd_req[d] = 1'b0; wr_req[d] = 1'b0;
    rd_addr[d] = '0;  wr_addr[d] = '0;
    wr_data[d] = '0;  prd[d] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(0);
    for (int n = 0; n < 4; n++) begin
      if (n > 0) next_cyc();
      #1;
      total++;
      if ({strobes(0), ovf[0], raddr[0], waddr[0]} !== '0 || wdo[0] !== '0 || rd_data[0] !== '0) begin
        bad++;
        $display("FAIL reset n=%0d got st=%b ovf=%b ra=%0d wa=%0d req all zero", n, strobes(0), ovf[0], raddr[0], waddr[0]);
      end
    end
  endtask

  task automatic test_read();
    logic seen = 1'b0;
    logic [6:0] es;
    logic [4:0] era, ewa;
    do_reset(0);
    rd_req[0] = 1'b1; rd_addr[0] = 5'd5;
    for (int n = 0; n < 14; n++) begin
      if (n > 0) next_cyc();
      if (seen) rd_req[0] = 1'b0;
      prd[0] = rnd325();
      #1;
      es  = (n == 4) ? 7'b1010000 : (n == 7) ? 7'b0000100 : (n == 8) ? 7'b0000001 : 7'b0;
      era = (n == 4) ? 5'd5 : 5'd0;
      ewa = (n == 7) ? 5'd5 : 5'd0;
      total++;
      if (strobes(0) !== es) begin
        bad++; $display("FAIL read_strobes n=%0d got=%b exp=%b", n, strobes(0), es);
      end
      total++;
      if ({raddr[0], waddr[0]} !== {era, ewa}) begin
        bad++; $display("FAIL read_addr n=%0d got=%0d/%0d exp=%0d/%0d", n, raddr[0], waddr[0], era, ewa);
      end
      total++;
      if (rd_data[0] !== ((n == 8) ? prd[0] : 325'd0)) begin
        bad++; $display("FAIL read_data n=%0d got=%h", n, rd_data[0]);
      end
      seen = rd_gnt[0];
    end
  endtask

  task automatic test_priority();
    logic rs = 1'b0, ws = 1'b0;
    logic [6:0] es;
    logic [4:0] era, ewa;
    logic [324:0] ewd;
    do_reset(0);
    rd_req[0] = 1'b1; rd_addr[0] = 5'd9;
    wr_req[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = '1;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) next_cyc();
      if (ws) begin wr_req[0] = 1'b0; wr_data[0] = rnd325(); end
      if (rs) rd_req[0] = 1'b0;
      #1;
      es  = (n == 4) ? 7'b0110000 : (n == 7) ? 7'b0000110 : (n == 8) ? 7'b1010000 :
            (n == 11) ? 7'b0000100 : (n == 12) ? 7'b0000001 : 7'b0;
      era = (n == 4) ? 5'd3 : (n == 8) ? 5'd9 : 5'd0;
      ewa = (n == 7) ? 5'd3 : (n == 11) ? 5'd9 : 5'd0;
      ewd = (n == 7) ? '1 : '0;
      total++;
      if (strobes(0) !== es) begin
        bad++; $display("FAIL prio_strobes n=%0d got=%b exp=%b", n, strobes(0), es);
      end
      total++;
      if ({raddr[0], waddr[0]} !== {era, ewa}) begin
        bad++; $display("FAIL prio_addr n=%0d got=%0d/%0d exp=%0d/%0d", n, raddr[0], waddr[0], era, ewa);
      end
      total++;
      if (wdo[0] !== ewd) begin
        bad++; $display("FAIL prio_wdata n=%0d got=%h exp=%h", n, wdo[0], ewd);
      end
      ws = wr_gnt[0];
      rs = rd_gnt[0];
    end
  endtask

  task automatic test_reset_midop();
    do_reset(0);
    rd_req[0] = 1'b1; rd_addr[0] = 5'd12;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) next_cyc();
      if (n == 5) rd_req[0] = 1'b0;
      rst[0] = (n == 6);
      prd[0] = rnd325();
      #1;
      if (n == 4) begin
        total++;
        if (rd_gnt[0] !== 1'b1) begin
          bad++; $display("FAIL midop_gnt got=%b exp=1", rd_gnt[0]);
        end
      end
      if (n >= 7) begin
        total++;
        if ({strobes(0), ovf[0], raddr[0], waddr[0]} !== '0 || wdo[0] !== '0 || rd_data[0] !== '0) begin
          bad++; $display("FAIL midop_quiet n=%0d got st=%b ra=%0d wa=%0d exp all zero", n, strobes(0), raddr[0], waddr[0]);
        end
      end
    end
  endtask

  task automatic test_refresh_idle();
    logic isref, iswb;
    logic [4:0] era, ewa;
    do_reset(1);
    for (int n = 0; n < 560; n++) begin
      if (n > 0) next_cyc();
      #1;
      isref = (n >= 20) && ((n - 20) % 16 == 0);
      iswb  = (n >= 23) && ((n - 23) % 16 == 0);
      era = isref ? 5'(((n - 20) / 16) % 32) : 5'd0;
      ewa = iswb  ? 5'(((n - 23) / 16) % 32) : 5'd0;
      total++;
      if (strobes(1) !== {3'b000, isref, iswb, 2'b00}) begin
        bad++; $display("FAIL refidle_strobes n=%0d got=%b exp=%b", n, strobes(1), {3'b000, isref, iswb, 2'b00});
      end
      total++;
      if ({raddr[1], waddr[1]} !== {era, ewa}) begin
        bad++; $display("FAIL refidle_row n=%0d got=%0d/%0d exp=%0d/%0d", n, raddr[1], waddr[1], era, ewa);
      end
    end
  endtask

  task automatic test_urgent();
    int pend = 0, rrow = 0, nref = 0;
    logic slot_ref = 1'b0, dec;
    logic [4:0] erow = 5'd7;
    do_reset(2);
    rd_req[2] = 1'b1; rd_addr[2] = 5'd7;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) next_cyc();
      #1;
      if (n % 4 == 0 && n >= 4) begin
        total++;
        if ({rd_gnt[2], en[2], refp[2], raddr[2]} !== {!slot_ref, !slot_ref, slot_ref, erow}) begin
          bad++; $display("FAIL urgent_slot n=%0d got gnt=%b ref=%b row=%0d exp ref=%b row=%0d", n, rd_gnt[2], refp[2], raddr[2], slot_ref, erow);
        end
      end
      dec = 1'b0;
      if (n % 4 == 3) begin
        slot_ref = (pend >= 3);
        if (slot_ref) begin
          erow = 5'(rrow); rrow = (rrow + 1) % 32; dec = 1'b1; nref++;
        end else begin
          erow = 5'd7;
        end
      end
      if (n % 8 == 7 && !dec) pend = (pend < 4) ? pend + 1 : pend;
      else if (dec && n % 8 != 7) pend--;
    end
    total++;
    if (nref < 5) begin
      bad++; $display("FAIL urgent_count got=%0d exp>=5", nref);
    end
  endtask

  task automatic test_overflow();
    do_reset(3);
    wr_req[3] = 1'b1; wr_addr[3] = 5'd1; wr_data[3] = rnd325();
    for (int n = 0; n < 90; n++) begin
      if (n > 0) next_cyc();
      #1;
      total++;
      if (ovf[3] !== (n >= 48)) begin
        bad++; $display("FAIL ovf_flag n=%0d got=%b exp=%b", n, ovf[3], (n >= 48));
      end
      if (n % 4 == 0 && n >= 4) begin
        total++;
        if ({wr_gnt[3], refp[3]} !== 2'b10) begin
          bad++; $display("FAIL ovf_slot n=%0d got wr=%b ref=%b exp wr=1 ref=0", n, wr_gnt[3], refp[3]);
        end
      end
    end
    do_reset(3);
    #1;
    total++;
    if (ovf[3] !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b exp=0", ovf[3]);
    end
  endtask

  task automatic test_random();
    int pend = 0, rrow = 0;
    logic eovf = 1'b0, rdg = 1'b0, wrg = 1'b0, dec, tick;
    for (int i = 0; i < 1024; i++) begin
      e_st[i] = '0; e_ra[i] = '0; e_wa[i] = '0; e_wd[i] = '0;
    end
    do_reset(1);
    for (int n = 0; n < 800; n++) begin
      if (n > 0) next_cyc();
      if (n % 4 == 1 || n == 0) begin
        if (!rd_req[1] || rdg) begin
          rd_req[1] = ($urandom_range(2) != 0); rd_addr[1] = 5'($urandom());
        end
        if (!wr_req[1] || wrg) begin
          wr_req[1] = ($urandom_range(3) == 0); wr_addr[1] = 5'($urandom()); wr_data[1] = rnd325();
        end
        rdg = 1'b0; wrg = 1'b0;
      end
      prd[1] = rnd325();
      #1;
      total++;
      if (strobes(1) !== e_st[n]) begin
        bad++; $display("FAIL rand_strobes n=%0d got=%b exp=%b", n, strobes(1), e_st[n]);
      end
      total++;
      if ({raddr[1], waddr[1]} !== {e_ra[n], e_wa[n]}) begin
        bad++; $display("FAIL rand_addr n=%0d got=%0d/%0d exp=%0d/%0d", n, raddr[1], waddr[1], e_ra[n], e_wa[n]);
      end
      total++;
      if (wdo[1] !== e_wd[n] || rd_data[1] !== (e_st[n][0] ? prd[1] : 325'd0)) begin
        bad++; $display("FAIL rand_data n=%0d got wd=%h rd=%h", n, wdo[1], rd_data[1]);
      end
      total++;
      if (ovf[1] !== eovf) begin
        bad++; $display("FAIL rand_ovf n=%0d got=%b exp=%b", n, ovf[1], eovf);
      end
      dec = 1'b0;
      if (n % 4 == 3) begin
        if (pend >= 3 || (!wr_req[1] && !rd_req[1] && pend > 0)) begin
          e_st[n+1] |= 7'b0001000; e_ra[n+1] = 5'(rrow);
          e_st[n+4] |= 7'b0000100; e_wa[n+4] = 5'(rrow);
          rrow = (rrow + 1) % 32; dec = 1'b1;
        end else if (wr_req[1]) begin
          e_st[n+1] |= 7'b0110000; e_ra[n+1] = wr_addr[1];
          e_st[n+4] |= 7'b0000110; e_wa[n+4] = wr_addr[1]; e_wd[n+4] = wr_data[1];
          wrg = 1'b1;
        end else if (rd_req[1]) begin
          e_st[n+1] |= 7'b1010000; e_ra[n+1] = rd_addr[1];
          e_st[n+4] |= 7'b0000100; e_wa[n+4] = rd_addr[1];
          e_st[n+5] |= 7'b0000001;
          rdg = 1'b1;
        end
      end
      tick = (n % 16 == 15);
      if (tick && !dec) begin
        if (pend == 4) eovf = 1'b1;
        else pend++;
      end else if (dec && !tick) begin
        pend--;
      end
      if (en[1] && refp[1]) begin
        total++; bad++;
        $display("FAIL rand_excl n=%0d got en=1 ref=1 exp exclusive", n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; rd_req[i] = 1'b0; wr_req[i] = 1'b0;
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0; prd[i] = '0;
    end
    test_reset();
    test_read();
    test_priority();
    test_reset_midop();
    test_refresh_idle();
    test_urgent();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edram_sched.md
# edram_sched

Slot scheduler and refresh controller for the 32-row × 325-bit eDRAM macro. Arbitrates one read requester, one write requester and an internal refresh engine onto the macro's single port, one operation per 4-clk slot. Sequences each operation's issue, ECC writeback and read-data return. Sits between the cache/fill logic and the eDRAM macro.

## Interface
- REF_INTERVAL, 256: clk cycles between refresh ticks.
- REF_PEND_MAX, 4: saturation value of the pending-refresh counter.
- REF_URGENT, 3: pending count at which refresh beats all requesters.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- rd_req  in  1  read request; held until rd_gnt.
- rd_addr  in  5  read row.
- rd_gnt  out  1  one-cycle pulse in issue cycle T.
- rd_valid  out  1  one-cycle pulse at T+4.
- rd_data  out  325  corrected row, valid with rd_valid.
- wr_req  in  1  write request; held until wr_gnt.
- wr_addr  in  5  write row.
- wr_data  in  325  write data; stable from request until grant.
- wr_gnt  out  1  one-cycle pulse in issue cycle T.
- ref_overflow  out  1  sticky: a refresh tick was lost at saturation.
- port_en  out  1  macro read/write enable, pulse at T.
- port_ref_plus2  out  1  macro refresh enable, pulse at T.
- port_read_addr  out  5  row at T.
- port_read_data  in  325  macro output, sampled at T+4.
- port_write_addr  out  5  writeback row, driven at T+3.
- port_write_data  out  325  write data, driven at T+3.
- port_wen_plus3  out  1  writeback enable, pulse at T+3.
- port_data_plus3  out  1  selects external write data, pulse at T+3 for writes only.

## Operation
- Phase counter: 2 bits, free-running 0..3 after reset. Issue occurs only in phase-0 cycles (T).
- Arbitration happens on the edge that ends phase 3. The winner is registered and issued in the next cycle.
- Priority order:
  1. Urgent refresh (pending ≥ REF_URGENT).
  2. Write.
  3. Read.
  4. Opportunistic refresh (pending > 0).
  5. Idle slot: no macro strobes.
- READ at T: port_en=1, port_read_addr=rd_addr, rd_gnt=1. At T+3: port_wen_plus3=1, port_write_addr=row (always writeback). At T+4: rd_valid=1, rd_data=port_read_data.
- WRITE at T: port_en=1, port_read_addr=wr_addr, wr_gnt=1. At T+3: port_wen_plus3=1, port_data_plus3=1, port_write_addr=row, port_write_data=captured wr_data.
  - wr_data is captured at T. The requester may change it from T+1.
- REFRESH at T: port_ref_plus2=1, port_read_addr=ref_row. At T+3: port_wen_plus3=1, port_write_addr=ref_row. Then ref_row increments, wrapping 31→0.
- Refresh timer: counts 0..REF_INTERVAL-1. On wrap, pending increments.
  - At pending=REF_PEND_MAX, a tick is lost and ref_overflow sets; only rst clears it.
- Refresh issue decrements pending. A tick and a refresh issue in the same cycle leave pending unchanged.
- Requests are level-sensitive. A request still high at the next arbitration edge after its grant counts as a new request.

## Timing
- Reset: phase=0, pending=0, ref_row=0, timer=0, ref_overflow=0, all strobes/grants/valids=0, addresses and data=0. The first issue cycle is the 4th cycle after rst drops.
- Reset during an operation: in-flight writeback and rd_valid are cancelled; no strobe appears after the rst cycle.
- Throughput: one operation per 4 clk. Read latency is grant at T to rd_valid at T+4.
- Back-to-back slots to the same row are ordered: writeback at T+3 precedes the next issue at T+4.
- Grants occur only in phase-0 cycles. There is never more than one grant per slot.
- port_en and port_ref_plus2 are never high together. port_data_plus3 implies port_wen_plus3.

## Test plan
- Reset, then rd_req=1, rd_addr=5 held from cycle 0 → rd_gnt, port_en and port_read_addr=5 at cycle 4; port_wen_plus3 with port_write_addr=5 at cycle 7; rd_valid at cycle 8 carrying port_read_data.
- wr_req and rd_req both asserted (wr_addr=3, wr_data=all-ones) → write granted first with port_data_plus3 at T+3 and data all-ones; read granted at T+4.
- REF_INTERVAL=16, no traffic → refresh issued every 16 cycles; ref_row steps 0,1,…,31,0; port_wen_plus3 follows each refresh by 3 cycles.
- Continuous read traffic with REF_INTERVAL=8 → pending climbs to 3; the next slot is a refresh that pre-empts the read; pending never exceeds 3.
- REF_PEND_MAX=2, REF_URGENT=3, continuous writes → pending saturates at 2; the third tick sets ref_overflow, which stays 1 until rst.
- rst asserted at T+2 of a read → no port_wen_plus3 and no rd_valid afterwards; all outputs 0.
